// File: rtl/adpll_tx_mod.sv
// -----------------------------------------------------------------------------
// adpll_tx_mod
// GFSK transmit-data sequencer feeding the ADPLL modulation input.
// Payload words are buffered in a small FIFO. When the block is enabled,
// in TX mode and the channel is locked, it sends a frame: an alternating
// 0,1,0,... preamble, then every queued word LSB-first. Each symbol lasts
// SYM_CYC clock cycles.
//
// Ports:
//   clk          reference clock
//   rst          asynchronous active-low reset
//   en           block enable
//   adpll_mode   ADPLL mode (PD=0, TEST=1, RX=2, TX=3)
//   channel_lock lock flag from adpll_ctr
//   FCW_mod      unsigned frequency deviation word
//   in_data      payload word, in_valid qualifies it, in_ready = FIFO not full
//   data_mod     current symbol (0 when idle)
//   fcw_offset   signed deviation: +FCW_mod / -FCW_mod / 0 when idle
//   tx_busy      frame in progress
//   done         one-cycle pulse at normal frame end
//   abort        one-cycle pulse when a frame is cut short by loss of go
// -----------------------------------------------------------------------------
module adpll_tx_mod #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int SYM_CYC  = 32,
  parameter int PRE_LEN  = 8,
  parameter int FCW_MODW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          adpll_mode,
  input  logic                channel_lock,
  input  logic [FCW_MODW-1:0] FCW_mod,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                data_mod,
  output logic [FCW_MODW:0]   fcw_offset,
  output logic                tx_busy,
  output logic                done,
  output logic                abort
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SYM_CYC);
  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] MODE_TX = 2'd3;

  // FIFO storage and bookkeeping
  logic [DW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  // Sequencer state
  logic [1:0]          r_state;
  logic [SW-1:0]       r_sym_cnt;
  logic [PW-1:0]       r_pre_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [DW-1:0]       r_shift;

  // Registered outputs
  logic                r_in_ready;
  logic                r_data_mod;
  logic [FCW_MODW:0]   r_fcw_offset;
  logic                r_tx_busy;
  logic                r_done;
  logic                r_abort;

  // Next-state values
  logic [1:0]          w_state_nxt;
  logic [SW-1:0]       w_sym_nxt;
  logic [PW-1:0]       w_pre_nxt;
  logic [BW-1:0]       w_bit_nxt;
  logic [DW-1:0]       w_shift_nxt;
  logic                w_dmod_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_abort_nxt;
  logic [FCW_MODW:0]   w_fcw_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic                w_pop;

  logic                w_go;
  logic                w_push;
  logic                w_nonempty;
  logic                w_sym_end;
  logic [DW-1:0]       w_head;
  logic [DW-1:0]       w_shift_dn;
  logic [FCW_MODW:0]   w_fcw_pos;
  logic [FCW_MODW:0]   w_fcw_neg;

  assign w_go       = en & (adpll_mode == MODE_TX) & channel_lock;
  // Full-ness comes from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign w_push     = in_valid & r_in_ready;
  assign w_nonempty = (r_count != {CW{1'b0}});
  assign w_sym_end  = (r_sym_cnt == SW'(SYM_CYC - 1));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_shift_dn = r_shift >> 1;
  assign w_fcw_pos  = {1'b0, FCW_mod};
  assign w_fcw_neg  = ~w_fcw_pos + {{FCW_MODW{1'b0}}, 1'b1};

  // Sequencer next-state: preamble, payload shifting, word chaining and abort
  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym_cnt;
    w_pre_nxt   = r_pre_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_dmod_nxt  = r_data_mod;
    w_busy_nxt  = r_tx_busy;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dmod_nxt = 1'b0;
        if (w_go && w_nonempty) begin
          w_state_nxt = ST_PRE;
          w_sym_nxt   = {SW{1'b0}};
          w_pre_nxt   = {PW{1'b0}};
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_PRE: begin
        if (!w_go) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_dmod_nxt  = 1'b0;
        end else if (w_sym_end) begin
          w_sym_nxt = {SW{1'b0}};
          if (r_pre_cnt == PW'(PRE_LEN - 1)) begin
            // Only this block pops, so the word that opened the frame is
            // still there; the empty branch is a defensive fallback.
            if (w_nonempty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_bit_nxt   = {BW{1'b0}};
              w_dmod_nxt  = w_head[0];
              w_state_nxt = ST_DATA;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_dmod_nxt  = 1'b0;
            end
          end else begin
            w_pre_nxt  = r_pre_cnt + PW'(1);
            w_dmod_nxt = ~r_data_mod;
          end
        end else begin
          w_sym_nxt = r_sym_cnt + SW'(1);
        end
      end
      ST_DATA: begin
        if (!w_go) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_dmod_nxt  = 1'b0;
        end else if (w_sym_end) begin
          w_sym_nxt = {SW{1'b0}};
          if (r_bit_cnt == BW'(DW - 1)) begin
            if (w_nonempty) begin
              // Chain the next word with no gap symbol
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_bit_nxt   = {BW{1'b0}};
              w_dmod_nxt  = w_head[0];
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_dmod_nxt  = 1'b0;
            end
          end else begin
            w_bit_nxt   = r_bit_cnt + BW'(1);
            w_shift_nxt = w_shift_dn;
            w_dmod_nxt  = w_shift_dn[0];
          end
        end else begin
          w_sym_nxt = r_sym_cnt + SW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_dmod_nxt  = 1'b0;
      end
    endcase
  end

  // Deviation word follows the symbol that will be on data_mod next cycle
  always_comb begin
    if (w_busy_nxt) begin
      w_fcw_nxt = w_dmod_nxt ? w_fcw_pos : w_fcw_neg;
    end else begin
      w_fcw_nxt = {(FCW_MODW + 1){1'b0}};
    end
  end

  // FIFO occupancy next value
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, count and ready flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Sequencer state and registered modulation outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_sym_cnt    <= {SW{1'b0}};
      r_pre_cnt    <= {PW{1'b0}};
      r_bit_cnt    <= {BW{1'b0}};
      r_shift      <= {DW{1'b0}};
      r_data_mod   <= 1'b0;
      r_fcw_offset <= {(FCW_MODW + 1){1'b0}};
      r_tx_busy    <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sym_cnt    <= w_sym_nxt;
      r_pre_cnt    <= w_pre_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_data_mod   <= w_dmod_nxt;
      r_fcw_offset <= w_fcw_nxt;
      r_tx_busy    <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign data_mod   = r_data_mod;
  assign fcw_offset = r_fcw_offset;
  assign tx_busy    = r_tx_busy;
  assign done       = r_done;
  assign abort      = r_abort;

endmodule

// File: tb/tb_adpll_tx_mod.sv
// -----------------------------------------------------------------------------
// tb_adpll_tx_mod
// Self-checking bench for adpll_tx_mod with default parameters. A queue holds
// the words the FIFO should contain. For each frame the expected symbol list
// is built as preamble (0,1,0,...) followed by every queued word LSB-first.
// Cycle c of the frame then carries symbol (c-1)/SYM.
// -----------------------------------------------------------------------------
module tb_adpll_tx_mod;

  localparam int DW   = 8;
  localparam int SYM  = 32;
  localparam int PRE  = 8;
  localparam int FW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          lock = 1'b0;
  logic [FW-1:0] fcw_mod = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          data_mod;
  logic [FW:0]   fcw_offset;
  logic          tx_busy;
  logic          done;
  logic          abort;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] model_q[$];

  adpll_tx_mod dut (
    .clk(clk), .rst(rst), .en(en), .adpll_mode(mode), .channel_lock(lock),
    .FCW_mod(fcw_mod), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_mod(data_mod), .fcw_offset(fcw_offset),
    .tx_busy(tx_busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push one word with transmission gated off; FIFO must have room
  task automatic push_word(input logic [DW-1:0] w);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL push_ready: in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    model_q.push_back(w);
  endtask

  // Start a frame and check it cycle by cycle. stop_c=0 runs to done,
  // otherwise channel lock is dropped after frame cycle stop_c.
  task automatic run_frame(input string tag, input int stop_c);
    int          stream[$];
    int          len;
    int          sym;
    bit          stopped;
    logic        exp_dm;
    logic [FW:0] exp_f;
    stream = {};
    for (int i = 0; i < PRE; i++) stream.push_back(i % 2);
    foreach (model_q[w]) begin
      for (int b = 0; b < DW; b++) stream.push_back(int'(model_q[w][b]));
    end
    len     = stream.size() * SYM;
    stopped = 1'b0;
    sym     = 0;
    en = 1'b1; mode = 2'd3; lock = 1'b1;
    for (int c = 1; c <= len && !stopped; c++) begin
      tick();
      exp_dm = stream[(c - 1) / SYM][0];
      exp_f  = exp_dm ? {1'b0, fcw_mod} : ({(FW+1){1'b0}} - {1'b0, fcw_mod});
      n_vec++;
      if ({tx_busy, data_mod, fcw_offset, done, abort} !== {1'b1, exp_dm, exp_f, 2'b00}) begin
        n_err++;
        $display("FAIL %s_sym cycle %0d: busy/dm/fcw/done/abort=%b/%b/%0d/%b/%b expected 1/%b/%0d/0/0",
                 tag, c, tx_busy, data_mod, $signed(fcw_offset), done, abort, exp_dm, $signed(exp_f));
      end
      if (stop_c != 0 && c == stop_c) begin
        stopped = 1'b1;
        sym     = (c - 1) / SYM;
      end
    end
    if (stopped) begin
      lock = 1'b0;
      tick();
      n_vec++;
      if ({tx_busy, data_mod, fcw_offset, done, abort} !== {2'b00, {(FW+1){1'b0}}, 2'b01}) begin
        n_err++;
        $display("FAIL %s_abort: busy/dm/fcw/done/abort=%b/%b/%0d/%b/%b expected 0/0/0/0/1",
                 tag, tx_busy, data_mod, $signed(fcw_offset), done, abort);
      end
      // Words already taken from the FIFO (including the one being sent) are gone
      if (sym >= PRE) begin
        for (int k = 0; k < (sym - PRE) / DW + 1; k++) void'(model_q.pop_front());
      end
      tick();
      n_vec++;
      if (abort !== 1'b0 || tx_busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s_abort_pulse: abort=%b busy=%b expected 0/0", tag, abort, tx_busy);
      end
    end else begin
      tick();
      n_vec++;
      if ({tx_busy, data_mod, fcw_offset, done, abort} !== {2'b00, {(FW+1){1'b0}}, 2'b10}) begin
        n_err++;
        $display("FAIL %s_done: busy/dm/fcw/done/abort=%b/%b/%0d/%b/%b expected 0/0/0/1/0",
                 tag, tx_busy, data_mod, $signed(fcw_offset), done, abort);
      end
      model_q.delete();
      lock = 1'b0;
      tick();
      n_vec++;
      if (done !== 1'b0 || tx_busy !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s_after: done=%b busy=%b in_ready=%b expected 0/0/1", tag, done, tx_busy, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, data_mod, fcw_offset, tx_busy, done, abort} !== {2'b10, {(FW+1){1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_values: rdy/dm/fcw/busy/done/abort=%b/%b/%0d/%b/%b/%b expected 1/0/0/0/0/0",
               in_ready, data_mod, $signed(fcw_offset), tx_busy, done, abort);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    // Mid-frame reset: 40 cycles in is preamble symbol 1 (data_mod=1)
    fcw_mod = 5'd7;
    push_word(DW'($urandom));
    en = 1'b1; mode = 2'd3; lock = 1'b1;
    repeat (40) tick();
    n_vec++;
    if (tx_busy !== 1'b1 || data_mod !== 1'b1) begin
      n_err++;
      $display("FAIL reset_preframe: busy=%b dm=%b expected 1/1", tx_busy, data_mod);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, data_mod, fcw_offset, tx_busy, done, abort} !== {2'b10, {(FW+1){1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_async: rdy/dm/fcw/busy/done/abort=%b/%b/%0d/%b/%b/%b expected 1/0/0/0/0/0",
               in_ready, data_mod, $signed(fcw_offset), tx_busy, done, abort);
    end
    model_q.delete();
    tick();
    rst = 1'b1;
    // Lock still asserted: FIFO contents were lost so no frame may start
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (tx_busy !== 1'b0 || data_mod !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_empty cycle %0d: busy=%b dm=%b rdy=%b expected 0/0/1", i, tx_busy, data_mod, in_ready);
      end
    end
    lock = 1'b0;
    tick();
  endtask

  task automatic test_single;
    fcw_mod = 5'd9;
    push_word(8'hA5);
    run_frame("single", 0);
  endtask

  task automatic test_back_to_back;
    fcw_mod = FW'($urandom_range(1, 31));
    push_word(8'h00);
    push_word(8'hFF);
    run_frame("b2b", 0);
  endtask

  task automatic test_fifo_full;
    logic [DW-1:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = DW'($urandom);
    fcw_mod  = FW'($urandom_range(0, 31));
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = w[k];
      tick();
      model_q.push_back(w[k]);
      n_vec++;
      if (in_ready !== (k < 3)) begin
        n_err++;
        $display("FAIL full_fill word %0d: in_ready=%b expected %b", k, in_ready, (k < 3));
      end
    end
    in_data = w[4];
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL full_hold cycle %0d: in_ready=%b expected 0", i, in_ready);
      end
    end
    en = 1'b1; mode = 2'd3; lock = 1'b1;
    for (int c = 1; c <= PRE * SYM + 1; c++) begin
      tick();
      n_vec++;
      if (in_ready !== (c == PRE * SYM + 1)) begin
        n_err++;
        $display("FAIL full_pop cycle %0d: in_ready=%b expected %b", c, in_ready, (c == PRE * SYM + 1));
      end
    end
    tick();
    model_q.push_back(w[4]);
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_accept5: in_ready=%b expected 0", in_ready);
    end
    // Abort during word 0; the remaining four words must follow in order
    lock = 1'b0;
    tick();
    void'(model_q.pop_front());
    n_vec++;
    if (abort !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_abort: abort=%b busy=%b expected 1/0", abort, tx_busy);
    end
    tick();
    run_frame("full_resume", 0);
  endtask

  task automatic test_abort;
    fcw_mod = FW'($urandom_range(1, 31));
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    run_frame("abort", (PRE + 3) * SYM + 1 + int'($urandom_range(0, SYM - 1)));
    n_vec++;
    if (in_ready !== 1'b1 || model_q.size() != 1) begin
      n_err++;
      $display("FAIL abort_count: in_ready=%b model words=%0d expected 1/1", in_ready, model_q.size());
    end
    run_frame("abort_resume", 0);
  endtask

  task automatic test_mode_gating;
    fcw_mod = FW'($urandom_range(1, 31));
    push_word(DW'($urandom));
    en = 1'b1; mode = 2'd2; lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (tx_busy !== 1'b0 || data_mod !== 1'b0 || fcw_offset !== {(FW+1){1'b0}}) begin
        n_err++;
        $display("FAIL mode_rx cycle %0d: busy=%b dm=%b fcw=%0d expected 0/0/0", i, tx_busy, data_mod, $signed(fcw_offset));
      end
    end
    run_frame("mode_tx", 0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 3; f++) begin
      fcw_mod = FW'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) push_word(DW'($urandom));
      run_frame("random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_mode_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
